// File: rtl/clk_div_integer.sv
// Integer clock divider for the UART RX sampling clock: even ratios at 50% duty, odd ratios with a longer low phase.
// Define CLKDIV_TICK_EN to add div_tick, a one-CLK strobe in the last cycle of each divided period.
module clk_div_integer #(
  parameter int RATIO_WD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clk_div_en,
  input  logic [RATIO_WD-1:0] div_ratio,
`ifdef CLKDIV_TICK_EN
  output logic                div_tick,
`endif
  output logic                div_clk
);

  localparam logic [RATIO_WD-2:0] CNT_ONE = {{(RATIO_WD-2){1'b0}}, 1'b1};
  localparam logic [RATIO_WD-1:0] R_ONE   = {{(RATIO_WD-1){1'b0}}, 1'b1};
  localparam logic [RATIO_WD-1:0] R_TWO   = {{(RATIO_WD-2){1'b0}}, 2'b10};

  logic [RATIO_WD-2:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;

  logic                bypass;
  logic [RATIO_WD-1:0] r_eff;
  logic [RATIO_WD:0]   r_plus1;
  logic [RATIO_WD-1:0] len_lo, len_hi, last_cnt;
  logic                at_last;

  assign bypass = !clk_div_en || (div_ratio < R_TWO);

  // A new ratio is only picked up at a period start so a running period always completes.
  assign r_eff    = (cnt_q == '0 && !phase_q) ? div_ratio : ratio_q;
  assign r_plus1  = {1'b0, r_eff} + {{RATIO_WD{1'b0}}, 1'b1};
  assign len_lo   = RATIO_WD'(r_plus1 >> 1);
  assign len_hi   = {1'b0, r_eff[RATIO_WD-1:1]};
  assign last_cnt = (phase_q ? len_hi : len_lo) - R_ONE;
  assign at_last  = ({1'b0, cnt_q} == last_cnt);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    ratio_d = ratio_q;
    if (bypass) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      ratio_d = div_ratio;
    end else begin
      ratio_d = r_eff;
      if (at_last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      ratio_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ratio_q <= ratio_d;
    end
  end

  // Select only switches cleanly at period boundaries; mid-period bypass may truncate a pulse.
  assign div_clk = bypass ? CLK : phase_q;

`ifdef CLKDIV_TICK_EN
  assign div_tick = !bypass && phase_q && at_last;
`endif

endmodule
